// File: rtl/regfile_access_ctrl.sv
// +-----------------------------------------------------------------------------
// | regfile_access_ctrl: read/writeback/debug arbiter in front of the RV32I
// | register file, with a forwarding write buffer.   Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module regfile_access_ctrl #(
  parameter int REG_DATA_W = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                  rf_clk,
  input  logic                  rf_ares_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_rs1,
  input  logic [ADDR_WIDTH-1:0] rd_rs2,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [REG_DATA_W-1:0] rd_data_a,
  output logic [REG_DATA_W-1:0] rd_data_b,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_DATA_W-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [REG_DATA_W-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [REG_DATA_W-1:0] dbg_rdata,
  output logic                  rf_cs,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] rw_dec,
  output logic [ADDR_WIDTH-1:0] ra_dec,
  output logic [ADDR_WIDTH-1:0] rb_dec,
  output logic [REG_DATA_W-1:0] w_data_in,
  input  logic [REG_DATA_W-1:0] qa_out,
  input  logic [REG_DATA_W-1:0] qb_out
);

  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [ADDR_WIDTH-1:0]   buf_addr [WBUF_DEPTH];
  logic [REG_DATA_W-1:0]   buf_data [WBUF_DEPTH];
  logic                    dbg_we_q;
  logic [ADDR_WIDTH-1:0]   dbg_addr_q;
  logic [REG_DATA_W-1:0]   dbg_wdata_q;

  logic                    full;
  logic                    push;
  logic                    pop;
  logic [CNT_W-1:0]        count_nxt;
  logic [CNT_W-1:0]        wr_idx;
  logic [REG_DATA_W-1:0]   fwd_a;
  logic [REG_DATA_W-1:0]   fwd_b;

  assign full      = (count == CNT_W'(WBUF_DEPTH));
  assign wb_ready  = (state == IDLE) && !full;
  assign rd_gnt    = (state == IDLE) && !full && rd_req;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push      = wb_valid && wb_ready && (wb_rd != '0);
  assign pop       = ((state == IDLE) || (state == DRAIN)) && (count != '0) && !rd_gnt;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign wr_idx    = count - CNT_W'(pop);

  // Entry 0 is the oldest, so a later match in the scan is younger.
  always_comb begin
    fwd_a = qa_out;
    fwd_b = qb_out;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (buf_addr[i] == rd_rs1)) fwd_a = buf_data[i];
      if ((CNT_W'(i) < count) && (buf_addr[i] == rd_rs2)) fwd_b = buf_data[i];
    end
    if (rd_rs1 == '0) fwd_a = '0;
    if (rd_rs2 == '0) fwd_b = '0;
  end

  always_comb begin
    rf_cs     = 1'b0;
    wr_en     = 1'b0;
    rw_dec    = '0;
    ra_dec    = '0;
    rb_dec    = '0;
    w_data_in = '0;
    if (pop) begin
      rf_cs     = 1'b1;
      wr_en     = 1'b1;
      rw_dec    = buf_addr[0];
      w_data_in = buf_data[0];
    end else if (rd_gnt) begin
      rf_cs  = 1'b1;
      ra_dec = rd_rs1;
      rb_dec = rd_rs2;
    end else if (state == ACCESS) begin
      rf_cs = 1'b1;
      if (dbg_we_q) begin
        wr_en     = 1'b1;
        rw_dec    = dbg_addr_q;
        w_data_in = (dbg_addr_q == '0) ? '0 : dbg_wdata_q;
      end else begin
        ra_dec = dbg_addr_q;
      end
    end
  end

  always_ff @(posedge rf_clk or negedge rf_ares_n) begin
    if (!rf_ares_n) begin
      count <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        if (push && (wr_idx == CNT_W'(i))) begin
          buf_addr[i] <= wb_rd;
          buf_data[i] <= wb_data;
        end else if (pop && (i < WBUF_DEPTH - 1)) begin
          buf_addr[i] <= buf_addr[i+1];
          buf_data[i] <= buf_data[i+1];
        end
      end
    end
  end

  always_ff @(posedge rf_clk or negedge rf_ares_n) begin
    if (!rf_ares_n) begin
      rd_vld    <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_vld <= rd_gnt;
      if (rd_gnt) begin
        rd_data_a <= fwd_a;
        rd_data_b <= fwd_b;
      end
    end
  end

  always_ff @(posedge rf_clk or negedge rf_ares_n) begin
    if (!rf_ares_n) begin
      state       <= IDLE;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_ack     <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_req) begin
            dbg_we_q    <= dbg_we;
            dbg_addr_q  <= dbg_addr;
            dbg_wdata_q <= dbg_wdata;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the buffer is (or becomes) empty this cycle.
          if (count_nxt == '0) state <= ACCESS;
        end
        ACCESS: begin
          if (!dbg_we_q) dbg_rdata <= (dbg_addr_q == '0) ? '0 : qa_out;
          dbg_ack <= 1'b1;
          state   <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
// +-----------------------------------------------------------------------------
// | tb_regfile_access_ctrl: directed vector bench with a register file model.
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_access_ctrl;

  localparam logic [31:0] A  = 32'hA5A5_0001;
  localparam int          NV = 30;

  logic        rf_clk = 1'b0;
  logic        rf_ares_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_rs1 = '0, rd_rs2 = '0;
  logic        rd_gnt, rd_vld;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        rf_cs, wr_en;
  logic [4:0]  rw_dec, ra_dec, rb_dec;
  logic [31:0] w_data_in, qa_out, qb_out;

  logic [31:0] rf [32] = '{default: '0};

  int tests = 0;
  int fails = 0;

  always #5 rf_clk = ~rf_clk;

  // Register file model: reads are zeroed while a write is in progress.
  assign qa_out = wr_en ? '0 : rf[ra_dec];
  assign qb_out = wr_en ? '0 : rf[rb_dec];
  always @(posedge rf_clk) if (rf_cs && wr_en) rf[rw_dec] <= w_data_in;

  regfile_access_ctrl dut (
    .rf_clk(rf_clk), .rf_ares_n(rf_ares_n),
    .rd_req(rd_req), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2), .rd_gnt(rd_gnt),
    .rd_vld(rd_vld), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_cs(rf_cs), .wr_en(wr_en), .rw_dec(rw_dec), .ra_dec(ra_dec), .rb_dec(rb_dec),
    .w_data_in(w_data_in), .qa_out(qa_out), .qb_out(qb_out)
  );

  typedef struct {
    logic [31:0] rd_req, rs1, rs2;
    logic [31:0] wbv, wbrd, wbd;
    logic [31:0] dreq, dwe, daddr, dwd;
    logic [31:0] e_gnt, e_rdy, e_cs, e_we, e_rw, e_ra, e_rb, e_wd;
    logic [31:0] e_vld, e_da, e_db, e_ack, e_dr;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic apply(input vec_t v);
    rd_req   = v.rd_req[0]; rd_rs1 = v.rs1[4:0]; rd_rs2 = v.rs2[4:0];
    wb_valid = v.wbv[0];    wb_rd  = v.wbrd[4:0]; wb_data = v.wbd;
    dbg_req  = v.dreq[0];   dbg_we = v.dwe[0];    dbg_addr = v.daddr[4:0];
    dbg_wdata = v.dwd;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d rd_gnt", i),    {31'd0, rd_gnt},    v.e_gnt);
    chk($sformatf("v%0d wb_ready", i),  {31'd0, wb_ready},  v.e_rdy);
    chk($sformatf("v%0d rf_cs", i),     {31'd0, rf_cs},     v.e_cs);
    chk($sformatf("v%0d wr_en", i),     {31'd0, wr_en},     v.e_we);
    chk($sformatf("v%0d rw_dec", i),    {27'd0, rw_dec},    v.e_rw);
    chk($sformatf("v%0d ra_dec", i),    {27'd0, ra_dec},    v.e_ra);
    chk($sformatf("v%0d rb_dec", i),    {27'd0, rb_dec},    v.e_rb);
    chk($sformatf("v%0d w_data_in", i), w_data_in,          v.e_wd);
    chk($sformatf("v%0d rd_vld", i),    {31'd0, rd_vld},    v.e_vld);
    chk($sformatf("v%0d rd_data_a", i), rd_data_a,          v.e_da);
    chk($sformatf("v%0d rd_data_b", i), rd_data_b,          v.e_db);
    chk($sformatf("v%0d dbg_ack", i),   {31'd0, dbg_ack},   v.e_ack);
    chk($sformatf("v%0d dbg_rdata", i), dbg_rdata,          v.e_dr);
  endtask

  initial begin
    //          rd rs1 rs2 | wbv rd data  | dreq we adr wdata        | gnt rdy cs we rw ra rb wd | vld da db ack dr
    vecs[0]  = '{0, 0, 0,  1, 5, A,      0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 1, 1, 1, 5, 0, 0, A,     0, 0, 0, 0, 0};
    vecs[2]  = '{1, 5, 0,  0, 0, 0,      0, 0, 0, 0,              1, 1, 1, 0, 0, 5, 0, 0,     0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 0, 0,     1, A, 0, 0, 0};
    vecs[4]  = '{1, 7, 5,  1, 7, 'h11,   0, 0, 0, 0,              1, 1, 1, 0, 0, 7, 5, 0,     0, A, 0, 0, 0};
    vecs[5]  = '{1, 7, 5,  1, 7, 'h22,   0, 0, 0, 0,              1, 1, 1, 0, 0, 7, 5, 0,     1, 0, A, 0, 0};
    vecs[6]  = '{1, 7, 0,  1, 8, 'h44,   0, 0, 0, 0,              0, 0, 1, 1, 7, 0, 0, 'h11,  1, 'h11, A, 0, 0};
    vecs[7]  = '{1, 7, 0,  1, 8, 'h44,   0, 0, 0, 0,              1, 1, 1, 0, 0, 7, 0, 0,     0, 'h11, A, 0, 0};
    vecs[8]  = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 1, 1, 7, 0, 0, 'h22,  1, 'h22, 0, 0, 0};
    vecs[9]  = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 1, 1, 1, 8, 0, 0, 'h44,  0, 'h22, 0, 0, 0};
    vecs[10] = '{1, 9, 8,  1, 9, 'h33,   0, 0, 0, 0,              1, 1, 1, 0, 0, 9, 8, 0,     0, 'h22, 0, 0, 0};
    vecs[11] = '{1, 9, 9,  0, 0, 0,      0, 0, 0, 0,              1, 1, 1, 0, 0, 9, 9, 0,     1, 0, 'h44, 0, 0};
    vecs[12] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 1, 1, 1, 9, 0, 0, 'h33,  1, 'h33, 'h33, 0, 0};
    vecs[13] = '{1, 0, 0,  1, 10, 'h55,  0, 0, 0, 0,              1, 1, 1, 0, 0, 0, 0, 0,     0, 'h33, 'h33, 0, 0};
    vecs[14] = '{1, 5, 10, 1, 11, 'h66,  1, 0, 5, 0,              1, 1, 1, 0, 0, 5, 10, 0,    1, 0, 0, 0, 0};
    vecs[15] = '{1, 1, 1,  1, 12, 'h77,  1, 0, 5, 0,              0, 0, 1, 1, 10, 0, 0, 'h55, 1, A, 'h55, 0, 0};
    vecs[16] = '{1, 1, 1,  1, 12, 'h77,  1, 0, 5, 0,              0, 0, 1, 1, 11, 0, 0, 'h66, 0, A, 'h55, 0, 0};
    vecs[17] = '{1, 1, 1,  1, 12, 'h77,  1, 0, 5, 0,              0, 0, 1, 0, 0, 5, 0, 0,     0, A, 'h55, 0, 0};
    vecs[18] = '{1, 1, 1,  1, 12, 'h77,  0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0,     0, A, 'h55, 1, A};
    vecs[19] = '{1, 1, 1,  1, 12, 'h77,  0, 0, 0, 0,              1, 1, 1, 0, 0, 1, 1, 0,     0, A, 'h55, 0, A};
    vecs[20] = '{0, 0, 0,  0, 0, 0,      1, 1, 0, 'hFFFF_FFFF,    0, 1, 1, 1, 12, 0, 0, 'h77, 1, 0, 0, 0, A};
    vecs[21] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, A};
    vecs[22] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 1, 1, 0, 0, 0, 0,     0, 0, 0, 0, A};
    vecs[23] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 1, A};
    vecs[24] = '{0, 0, 0,  0, 0, 0,      1, 0, 0, 0,              0, 1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, A};
    vecs[25] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, A};
    vecs[26] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0, A};
    vecs[27] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 1, 0};
    vecs[28] = '{0, 0, 0,  1, 0, 'hDEAD, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};
    vecs[29] = '{0, 0, 0,  0, 0, 0,      0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0};

    // Reset state, with a writeback offered that must be ignored.
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h123;
    repeat (2) @(negedge rf_clk);
    #1;
    chk("reset rd_vld",    {31'd0, rd_vld},   0);
    chk("reset rd_data_a", rd_data_a,         0);
    chk("reset rd_data_b", rd_data_b,         0);
    chk("reset dbg_ack",   {31'd0, dbg_ack},  0);
    chk("reset dbg_rdata", dbg_rdata,         0);
    chk("reset rf_cs",     {31'd0, rf_cs},    0);
    chk("reset wb_ready",  {31'd0, wb_ready}, 1);
    @(negedge rf_clk);
    idle_inputs();
    rf_ares_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge rf_clk);
      apply(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Reset while draining: buffered write and debug read are both discarded.
    @(negedge rf_clk);
    idle_inputs();
    rd_req = 1'b1; rd_rs1 = 5'd13;
    wb_valid = 1'b1; wb_rd = 5'd13; wb_data = 32'h99;
    #1 chk("rst-seq grant0", {31'd0, rd_gnt}, 1);
    @(negedge rf_clk);
    wb_valid = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd13;
    #1 chk("rst-seq grant1", {31'd0, rd_gnt}, 1);
    @(negedge rf_clk);
    idle_inputs();
    #1;
    chk("rst-seq drain wb_ready", {31'd0, wb_ready}, 0);
    chk("rst-seq drain wr_en",    {31'd0, wr_en},    1);
    chk("rst-seq drain rw_dec",   {27'd0, rw_dec},   13);
    chk("rst-seq pre rd_vld",     {31'd0, rd_vld},   1);
    chk("rst-seq pre rd_data_a",  rd_data_a,         32'h99);
    #1 rf_ares_n = 1'b0;
    #1;
    chk("rst-seq rd_vld",    {31'd0, rd_vld},   0);
    chk("rst-seq rd_data_a", rd_data_a,         0);
    chk("rst-seq rd_data_b", rd_data_b,         0);
    chk("rst-seq dbg_ack",   {31'd0, dbg_ack},  0);
    chk("rst-seq dbg_rdata", dbg_rdata,         0);
    chk("rst-seq wb_ready",  {31'd0, wb_ready}, 1);
    chk("rst-seq rf_cs",     {31'd0, rf_cs},    0);
    @(negedge rf_clk);
    rf_ares_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge rf_clk);
      #1;
      chk($sformatf("post-rst%0d rf_cs", i),    {31'd0, rf_cs},    0);
      chk($sformatf("post-rst%0d dbg_ack", i),  {31'd0, dbg_ack},  0);
      chk($sformatf("post-rst%0d wb_ready", i), {31'd0, wb_ready}, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
